dds_sweep_ctrl: RTL and testbench



---
 rtl/dds_sweep_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_dds_sweep_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_sweep_ctrl.sv
// DDS frequency-sweep sequencer.
// Steps a frequency word from a start point to an inclusive stop point in
// fixed increments, holding each point for a programmable number of clocks.
// Supports single sweep, sawtooth repeat and triangle modes.
module dds_sweep_ctrl #(
    parameter int FW = 32,
    parameter int PW = 12,
    parameter int DW = 24
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Stop,
    input  logic [1:0]    Mode,
    input  logic [FW-1:0] Start_Fword,
    input  logic [FW-1:0] Stop_Fword,
    input  logic [FW-1:0] Step_Fword,
    input  logic [DW-1:0] Dwell,
    input  logic [PW-1:0] Pword_In,
    output logic [FW-1:0] Fword,
    output logic [PW-1:0] Pword,
    output logic          Busy,
    output logic          Step_Tick,
    output logic          Done,
    output logic          Err
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DWELL = 1'b1
    } state_t;

    localparam logic [1:0] MODE_SINGLE = 2'd0;
    localparam logic [1:0] MODE_SAW    = 2'd1;
    localparam logic [1:0] MODE_TRI    = 2'd2;
    localparam logic [1:0] MODE_RSVD   = 2'd3;

    state_t        state_q;
    logic          dir_down_q;
    logic [1:0]    mode_q;
    logic [FW-1:0] start_q;
    logic [FW-1:0] stop_q;
    logic [FW-1:0] step_q;
    logic [DW-1:0] dwell_q;
    logic [DW-1:0] count_q;
    logic [FW-1:0] fword_q;
    logic [PW-1:0] pword_q;
    logic          busy_q;
    logic          tick_q;
    logic          done_q;
    logic          err_q;

    // Candidate next points, computed one bit wider so neither direction can wrap.
    logic [FW:0]   up_sum_d;
    logic [FW:0]   dn_diff_d;
    logic          up_ok_d;
    logic          dn_ok_d;
    logic          last_d;
    logic          cfg_valid_d;

    // Next-point arithmetic, range checks and start-request validation.
    always_comb begin
        up_sum_d    = {1'b0, fword_q} + {1'b0, step_q};
        dn_diff_d   = {1'b0, fword_q} - {1'b0, step_q};
        up_ok_d     = (up_sum_d <= {1'b0, stop_q});
        dn_ok_d     = (dn_diff_d[FW] == 1'b0) && (dn_diff_d[FW-1:0] >= start_q);
        last_d      = (count_q == (dwell_q - {{(DW-1){1'b0}}, 1'b1}));
        cfg_valid_d = (Step_Fword != {FW{1'b0}}) && (Start_Fword <= Stop_Fword);
    end

    // Sweep state machine: latches configuration, advances points, drives pulses.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            dir_down_q <= 1'b0;
            mode_q     <= 2'd0;
            start_q    <= {FW{1'b0}};
            stop_q     <= {FW{1'b0}};
            step_q     <= {FW{1'b0}};
            dwell_q    <= {DW{1'b0}};
            count_q    <= {DW{1'b0}};
            fword_q    <= {FW{1'b0}};
            pword_q    <= {PW{1'b0}};
            busy_q     <= 1'b0;
            tick_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // Pulses default low; only one of them is raised in any cycle.
            tick_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (Stop) begin
                // Abort wins over everything; frequency and phase words freeze.
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (Start) begin
                            if (cfg_valid_d) begin
                                mode_q     <= (Mode == MODE_RSVD) ? MODE_SINGLE : Mode;
                                start_q    <= Start_Fword;
                                stop_q     <= Stop_Fword;
                                step_q     <= Step_Fword;
                                dwell_q    <= (Dwell == {DW{1'b0}}) ? {{(DW-1){1'b0}}, 1'b1} : Dwell;
                                fword_q    <= Start_Fword;
                                pword_q    <= Pword_In;
                                count_q    <= {DW{1'b0}};
                                dir_down_q <= 1'b0;
                                busy_q     <= 1'b1;
                                tick_q     <= 1'b1;
                                state_q    <= ST_DWELL;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                    ST_DWELL: begin
                        if (!last_d) begin
                            count_q <= count_q + {{(DW-1){1'b0}}, 1'b1};
                        end else begin
                            count_q <= {DW{1'b0}};
                            if (dir_down_q) begin
                                // Descending leg of the triangle.
                                tick_q <= 1'b1;
                                if (dn_ok_d) begin
                                    fword_q <= dn_diff_d[FW-1:0];
                                end else begin
                                    dir_down_q <= 1'b0;
                                    if (up_ok_d) begin
                                        fword_q <= up_sum_d[FW-1:0];
                                    end else begin
                                        fword_q <= fword_q;
                                    end
                                end
                            end else if (up_ok_d) begin
                                fword_q <= up_sum_d[FW-1:0];
                                tick_q  <= 1'b1;
                            end else begin
                                // Next point would pass the stop limit.
                                case (mode_q)
                                    MODE_SAW: begin
                                        fword_q <= start_q;
                                        tick_q  <= 1'b1;
                                    end
                                    MODE_TRI: begin
                                        tick_q <= 1'b1;
                                        if (dn_ok_d) begin
                                            dir_down_q <= 1'b1;
                                            fword_q    <= dn_diff_d[FW-1:0];
                                        end else begin
                                            fword_q <= fword_q;
                                        end
                                    end
                                    default: begin
                                        state_q <= ST_IDLE;
                                        busy_q  <= 1'b0;
                                        done_q  <= 1'b1;
                                    end
                                endcase
                            end
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign Fword     = fword_q;
    assign Pword     = pword_q;
    assign Busy      = busy_q;
    assign Step_Tick = tick_q;
    assign Done      = done_q;
    assign Err       = err_q;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Directed bench for dds_sweep_ctrl: each task drives one scenario and
// checks the outputs against hand-derived sequences.
module tb_dds_sweep_ctrl;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0;
    logic        Stop = 1'b0;
    logic [1:0]  Mode = 2'd0;
    logic [31:0] Start_Fword = 32'd0;
    logic [31:0] Stop_Fword = 32'd0;
    logic [31:0] Step_Fword = 32'd0;
    logic [23:0] Dwell = 24'd0;
    logic [11:0] Pword_In = 12'd0;
    logic [31:0] Fword;
    logic [11:0] Pword;
    logic        Busy;
    logic        Step_Tick;
    logic        Done;
    logic        Err;

    int total = 0;
    int bad = 0;

    dds_sweep_ctrl #(.FW(32), .PW(12), .DW(24)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Stop(Stop), .Mode(Mode),
        .Start_Fword(Start_Fword), .Stop_Fword(Stop_Fword), .Step_Fword(Step_Fword),
        .Dwell(Dwell), .Pword_In(Pword_In), .Fword(Fword), .Pword(Pword),
        .Busy(Busy), .Step_Tick(Step_Tick), .Done(Done), .Err(Err)
    );

    always #10 Clk = ~Clk;

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic cfg(input logic [1:0] m, input logic [31:0] s, input logic [31:0] e,
                       input logic [31:0] st, input logic [23:0] d, input logic [11:0] p);
        Mode = m; Start_Fword = s; Stop_Fword = e; Step_Fword = st; Dwell = d; Pword_In = p;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        #25;
        total++;
        if ({Fword, Pword, Busy, Step_Tick, Done, Err} !== {32'd0, 12'd0, 4'b0000}) begin
            bad++;
            $display("FAIL reset_outputs got F=%0h P=%0h B=%b T=%b D=%b E=%b exp all zero",
                     Fword, Pword, Busy, Step_Tick, Done, Err);
        end
        @(negedge Clk);
        Reset = 1'b0;
        step();
    endtask

    task automatic test_single_up();
        logic [31:0] ef;
        cfg(2'd0, 32'd100, 32'd130, 32'd10, 24'd3, 12'h5A5);
        Start = 1'b1; step(); Start = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            ef = (c <= 12) ? 32'd100 + 32'd10 * 32'((c - 1) / 3) : 32'd130;
            total++;
            if (Fword !== ef || Busy !== (c <= 12) || Done !== (c == 13) ||
                Step_Tick !== (c <= 12 && (c - 1) % 3 == 0)) begin
                bad++;
                $display("FAIL single_up c=%0d got F=%0d B=%b D=%b T=%b exp F=%0d", c, Fword, Busy, Done, Step_Tick, ef);
            end
            if (c == 1) begin
                total++;
                if (Pword !== 12'h5A5) begin
                    bad++;
                    $display("FAIL single_pword got=%0h exp=5a5", Pword);
                end
            end
            step();
        end
    endtask

    task automatic test_nonmultiple();
        logic [31:0] ef;
        cfg(2'd0, 32'd100, 32'd125, 32'd10, 24'd3, 12'h001);
        Start = 1'b1; step(); Start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            ef = (c <= 9) ? 32'd100 + 32'd10 * 32'((c - 1) / 3) : 32'd120;
            total++;
            if (Fword !== ef || Busy !== (c <= 9) || Done !== (c == 10)) begin
                bad++;
                $display("FAIL nonmultiple c=%0d got F=%0d B=%b D=%b exp F=%0d", c, Fword, Busy, Done, ef);
            end
            step();
        end
    endtask

    task automatic test_top_boundary();
        cfg(2'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h10, 24'd0, 12'h002);
        Start = 1'b1; step(); Start = 1'b0;
        total++;
        if (Fword !== 32'hFFFF_FFF0 || Busy !== 1'b1 || Step_Tick !== 1'b1) begin
            bad++;
            $display("FAIL top_first got F=%0h B=%b T=%b exp F=fffffff0 B=1 T=1", Fword, Busy, Step_Tick);
        end
        step();
        total++;
        if (Fword !== 32'hFFFF_FFF0 || Busy !== 1'b0 || Done !== 1'b1 || Step_Tick !== 1'b0) begin
            bad++;
            $display("FAIL top_done got F=%0h B=%b D=%b T=%b exp F=fffffff0 B=0 D=1 T=0", Fword, Busy, Done, Step_Tick);
        end
        step();
    endtask

    task automatic test_triangle();
        logic [31:0] seq [9];
        seq = '{32'd0, 32'd5, 32'd10, 32'd5, 32'd0, 32'd5, 32'd10, 32'd5, 32'd0};
        cfg(2'd2, 32'd0, 32'd10, 32'd5, 24'd1, 12'h003);
        Start = 1'b1; step(); Start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            total++;
            if (Fword !== seq[c-1] || Busy !== 1'b1 || Step_Tick !== 1'b1) begin
                bad++;
                $display("FAIL triangle c=%0d got F=%0d B=%b T=%b exp F=%0d", c, Fword, Busy, Step_Tick, seq[c-1]);
            end
            if (c == 9) Stop = 1'b1;
            step();
        end
        Stop = 1'b0;
        total++;
        if (Fword !== 32'd0 || Busy !== 1'b0 || Done !== 1'b0) begin
            bad++;
            $display("FAIL triangle_stop got F=%0d B=%b D=%b exp F=0 B=0 D=0", Fword, Busy, Done);
        end
        step();
    endtask

    task automatic test_sawtooth();
        logic [31:0] seq [7];
        seq = '{32'd0, 32'd5, 32'd10, 32'd0, 32'd5, 32'd10, 32'd0};
        cfg(2'd1, 32'd0, 32'd10, 32'd5, 24'd1, 12'h004);
        Start = 1'b1; step(); Start = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            total++;
            if (Fword !== seq[c-1] || Busy !== 1'b1 || Step_Tick !== 1'b1 || Done !== 1'b0) begin
                bad++;
                $display("FAIL sawtooth c=%0d got F=%0d B=%b T=%b exp F=%0d", c, Fword, Busy, Step_Tick, seq[c-1]);
            end
            if (c == 7) Stop = 1'b1;
            step();
        end
        Stop = 1'b0;
        step();
    endtask

    task automatic test_stop_mid_dwell();
        logic [31:0] ef;
        cfg(2'd1, 32'd0, 32'd10, 32'd5, 24'd4, 12'h005);
        Start = 1'b1; step(); Start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            ef = (c <= 4) ? 32'd0 : 32'd5;
            total++;
            if (Fword !== ef || Busy !== 1'b1 || Step_Tick !== (c == 1 || c == 5) || Err !== 1'b0) begin
                bad++;
                $display("FAIL busy_start c=%0d got F=%0d B=%b T=%b E=%b exp F=%0d", c, Fword, Busy, Step_Tick, Err, ef);
            end
            if (c == 2) begin
                Start = 1'b1;
                cfg(2'd0, 32'd50, 32'd90, 32'd7, 24'd1, 12'h0FF);
            end
            if (c == 6) Stop = 1'b1;
            step();
            Start = 1'b0;
        end
        Stop = 1'b0;
        total++;
        if (Fword !== 32'd5 || Busy !== 1'b0 || Done !== 1'b0 || Step_Tick !== 1'b0 || Pword !== 12'h005) begin
            bad++;
            $display("FAIL stop_mid got F=%0d B=%b D=%b T=%b P=%0h exp F=5 B=0 D=0 T=0 P=5", Fword, Busy, Done, Step_Tick, Pword);
        end
        step();
        total++;
        if (Fword !== 32'd5 || Busy !== 1'b0) begin
            bad++;
            $display("FAIL stop_hold got F=%0d B=%b exp F=5 B=0", Fword, Busy);
        end
    endtask

    task automatic test_start_and_stop();
        cfg(2'd0, 32'd0, 32'd10, 32'd5, 24'd1, 12'h006);
        Start = 1'b1; Stop = 1'b1; step(); Start = 1'b0; Stop = 1'b0;
        total++;
        if (Busy !== 1'b0 || Err !== 1'b0 || Step_Tick !== 1'b0 || Fword !== 32'd5) begin
            bad++;
            $display("FAIL start_stop got B=%b E=%b T=%b F=%0d exp B=0 E=0 T=0 F=5", Busy, Err, Step_Tick, Fword);
        end
        step();
        total++;
        if (Busy !== 1'b0 || Fword !== 32'd5) begin
            bad++;
            $display("FAIL start_stop_idle got B=%b F=%0d exp B=0 F=5", Busy, Fword);
        end
    endtask

    task automatic test_err();
        for (int k = 0; k < 2; k++) begin
            if (k == 0) cfg(2'd0, 32'd0, 32'd10, 32'd0, 24'd1, 12'h007);
            else        cfg(2'd0, 32'd200, 32'd100, 32'd5, 24'd1, 12'h007);
            Start = 1'b1; step(); Start = 1'b0;
            total++;
            if (Err !== 1'b1 || Busy !== 1'b0 || Step_Tick !== 1'b0 || Fword !== 32'd5 || Pword !== 12'h005) begin
                bad++;
                $display("FAIL err_pulse k=%0d got E=%b B=%b T=%b F=%0d P=%0h exp E=1 B=0 T=0 F=5 P=5", k, Err, Busy, Step_Tick, Fword, Pword);
            end
            step();
            total++;
            if (Err !== 1'b0 || Busy !== 1'b0) begin
                bad++;
                $display("FAIL err_clear k=%0d got E=%b B=%b exp E=0 B=0", k, Err, Busy);
            end
        end
    endtask

    task automatic test_reset_mid();
        cfg(2'd1, 32'd20, 32'd40, 32'd5, 24'd1, 12'h008);
        Start = 1'b1; step(); Start = 1'b0;
        step(); step();
        total++;
        if (Busy !== 1'b1 || Fword !== 32'd30) begin
            bad++;
            $display("FAIL reset_mid_pre got B=%b F=%0d exp B=1 F=30", Busy, Fword);
        end
        #5 Reset = 1'b1;
        #1;
        total++;
        if (Fword !== 32'd0 || Busy !== 1'b0 || Step_Tick !== 1'b0 || Pword !== 12'd0) begin
            bad++;
            $display("FAIL reset_mid got F=%0d B=%b T=%b P=%0h exp all zero", Fword, Busy, Step_Tick, Pword);
        end
        step();
        @(negedge Clk);
        Reset = 1'b0;
        step();
        total++;
        if (Fword !== 32'd0 || Busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_after got F=%0d B=%b exp F=0 B=0", Fword, Busy);
        end
    endtask

    initial begin
        test_reset();
        test_single_up();
        test_nonmultiple();
        test_top_boundary();
        test_triangle();
        test_sawtooth();
        test_stop_mid_dwell();
        test_start_and_stop();
        test_err();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
